// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD sum display.
// Used by bcd_to_seg and bcd_sum_display.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    DIG_UNITS = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUND  = 2'd2
  } dig_idx_t;

  localparam logic [2:0] AN_UNITS = 3'b110;
  localparam logic [2:0] AN_TENS  = 3'b101;
  localparam logic [2:0] AN_HUND  = 3'b011;
  localparam logic [2:0] AN_NONE  = 3'b111;

  typedef struct packed {
    logic       co;
    logic [3:0] tens;
    logic [3:0] units;
  } held_t;

  function automatic logic [6:0] digit_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Nibble to 7-segment decoder with blanking.
// A non-BCD nibble always shows "E", even when blank is requested.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic is_e;

  assign is_e = (nibble_i > 4'd9);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (1'b1)
      is_e:              seg_o = SEG_E;
      (blank_i && !is_e): seg_o = SEG_BLANK;
      default:           seg_o = digit_seg(nibble_i);
    endcase
  end

endmodule

// File: rtl/bcd_sum_display.sv
// Holding register + 3-digit multiplexed 7-segment driver for a BCD sum.
// Define LEADING_ZERO_BLANK_EN to blank leading zero hundreds/tens digits.
module bcd_sum_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sum_in,
  input  logic       co_in,
  input  logic       in_valid,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  held_t      held_q, held_d;
  logic       err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dig_idx_t   idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [2:0] an_q, an_d;

  logic [3:0] nib;
  logic       blank;
  logic       lz_hund;
  logic       lz_tens;
  logic       wrap;

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_hund = ~held_q.co;
  assign lz_tens = ~held_q.co & (held_q.tens == 4'd0);
`else
  assign lz_hund = 1'b0;
  assign lz_tens = 1'b0;
`endif

  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    held_d = held_q;
    err_d  = err_q;
    if (in_valid) begin
      held_d = '{co: co_in,
                 tens: sum_in[7:4],
                 units: sum_in[3:0]};
      err_d  = (sum_in[7:4] > 4'd9) |
               (sum_in[3:0] > 4'd9);
    end
  end

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    unique case (idx_q)
      DIG_UNITS: if (wrap) idx_d = DIG_TENS;
      DIG_TENS:  if (wrap) idx_d = DIG_HUND;
      DIG_HUND:  if (wrap) idx_d = DIG_UNITS;
      default:   idx_d = DIG_UNITS;
    endcase
  end

  // Digit select feeds the output registers from the current index.
  always_comb begin
    nib   = held_q.units;
    blank = 1'b0;
    an_d  = AN_UNITS;
    unique case (idx_q)
      DIG_UNITS: begin
        nib   = held_q.units;
        blank = 1'b0;
        an_d  = AN_UNITS;
      end
      DIG_TENS: begin
        nib   = held_q.tens;
        blank = lz_tens;
        an_d  = AN_TENS;
      end
      DIG_HUND: begin
        nib   = {3'b000, held_q.co};
        blank = lz_hund;
        an_d  = AN_HUND;
      end
      default: begin
        nib   = 4'd0;
        blank = 1'b1;
        an_d  = AN_UNITS;
      end
    endcase
  end

  bcd_to_seg u_dec (
    .nibble_i (nib),
    .blank_i  (blank),
    .seg_o    (seg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= DIG_UNITS;
      seg_q  <= SEG_BLANK;
      an_q   <= AN_NONE;
    end else begin
      held_q <= held_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Self-checking bench for bcd_sum_display with REFRESH_DIV=4.
// Reference model tracks the held value and scan position arithmetically.
module tb_bcd_sum_display;

  localparam int R = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] sum_in;
  logic       co_in;
  logic       in_valid;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err;

  int checks;
  int passed;

  int e;
  int mco, mt, mu;

  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_sum_display #(.REFRESH_DIV(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_in   (sum_in),
    .co_in    (co_in),
    .in_valid (in_valid),
    .seg      (seg),
    .an       (an),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic logic [6:0] mseg(input int v);
    if (v > 9) return 7'h79;
    return lut[v];
  endfunction

  function automatic logic [6:0] exp_digit(input int d);
    logic [6:0] s;
    case (d)
      0: s = mseg(mu);
      1: s = (BLANK_EN && mco == 0 && mt == 0)
             ? 7'h00 : mseg(mt);
      default: s = (BLANK_EN && mco == 0)
             ? 7'h00 : mseg(mco);
    endcase
    return s;
  endfunction

  function automatic int cur_digit();
    return ((e - 1) / R) % 3;
  endfunction

  task automatic model_reset();
    e = 0;
    mco = 0;
    mt = 0;
    mu = 0;
  endtask

  task automatic step();
    logic       cap;
    logic [7:0] cs;
    logic       cc;
    int         d;
    logic [6:0] es;
    logic [2:0] ea;
    @(posedge clk);
    cap = in_valid;
    cs  = sum_in;
    cc  = co_in;
    #1;
    e++;
    d  = cur_digit();
    es = exp_digit(d);
    ea = 3'b111;
    ea[d] = 1'b0;
    if (cap) begin
      mco = int'(cc);
      mt  = int'(cs[7:4]);
      mu  = int'(cs[3:0]);
    end
    chk("seg", {1'b0, seg}, {1'b0, es});
    chk("an", {5'b0, an}, {5'b0, ea});
    chk("err", {7'b0, err},
        {7'b0, (mt > 9 || mu > 9)});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [7:0] s,
                      input logic c);
    sum_in   = s;
    co_in    = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sum_in   = 8'h00;
    co_in    = 1'b0;
    model_reset();

    #12;
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_an", {5'b0, an}, 8'h07);
    chk("rst_err", {7'b0, err}, 8'h00);
    rst_n = 1'b1;

    step();
    chk("first_an", {5'b0, an}, 8'h06);
    chk("first_seg", {1'b0, seg}, 8'h3F);
    steps(2);

    load(8'h47, 1'b1);
    steps(12);

    load(8'h3C, 1'b0);
    chk("err_3c", {7'b0, err}, 8'h01);
    steps(6);
    load(8'h12, 1'b0);
    chk("err_12", {7'b0, err}, 8'h00);
    steps(4);

    for (int k = 0; k < 20; k++) begin
      if (cur_digit() == 1 && ((e - 1) % R) < R - 1)
        break;
      step();
    end
    chk("tens_ready", 8'(cur_digit()), 8'h01);
    load(8'h99, 1'b0);
    step();
    chk("tens_99", {1'b0, seg}, 8'h6F);
    steps(4);

    load(8'h05, 1'b0);
    steps(12);

    sum_in   = 8'h11;
    co_in    = 1'b0;
    in_valid = 1'b1;
    step();
    sum_in = 8'h22;
    step();
    sum_in = 8'h33;
    step();
    in_valid = 1'b0;
    steps(12);

    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom_range(0, 4) == 0);
      co_in    = 1'($urandom_range(0, 1));
      sum_in[7:4] = ($urandom_range(0, 3) == 0)
        ? 4'($urandom_range(0, 15))
        : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) sum_in[7:4] = 4'd0;
      sum_in[3:0] = ($urandom_range(0, 3) == 0)
        ? 4'($urandom_range(0, 15))
        : 4'($urandom_range(0, 9));
      step();
    end
    in_valid = 1'b0;

    load(8'h64, 1'b1);
    steps(5);
    #3;
    sum_in   = 8'h88;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_seg", {1'b0, seg}, 8'h00);
    chk("mid_rst_an", {5'b0, an}, 8'h07);
    chk("mid_rst_err", {7'b0, err}, 8'h00);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    step();
    chk("rel_an", {5'b0, an}, 8'h06);
    chk("rel_seg", {1'b0, seg}, 8'h3F);
    steps(12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
